// File: rtl/raster_cmd_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : raster_cmd_queue_pkg
// Description : Shared types for the rasterizer command queue.
// Revision    : 1.0
// ============================================================================
package raster_cmd_queue_pkg;

    typedef enum logic [2:0] {
        RASTER_CMD_NOP   = 3'd0,
        RASTER_CMD_POINT = 3'd1,
        RASTER_CMD_LINE  = 3'd2,
        RASTER_CMD_RECT  = 3'd3,
        RASTER_CMD_FILL  = 3'd4
    } raster_command_t;

    typedef struct packed {
        raster_command_t command;
        logic [7:0]      x0;
        logic [7:0]      y0;
        logic [7:0]      x1;
        logic [7:0]      y1;
        logic [2:0]      colour;
    } raster_queue_entry_t;

    localparam int RASTER_QUEUE_DEPTH = 8;
    localparam int RASTER_ENTRY_W     = $bits(raster_queue_entry_t);

endpackage
`default_nettype wire

// File: rtl/raster_cmd_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO; push when full / pop when empty
//               are ignored.
// Revision    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/raster_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : raster_cmd_queue
// Description : Buffers CPU draw commands and issues them one at a time to the
//               rasterizer with a one-cycle request and a held payload.
// Revision    : 1.0
// ============================================================================
module raster_cmd_queue
    import raster_cmd_queue_pkg::*;
#(
    parameter int DEPTH = RASTER_QUEUE_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  raster_command_t  cmd_command,
    input  logic [7:0]       cmd_x0,
    input  logic [7:0]       cmd_y0,
    input  logic [7:0]       cmd_x1,
    input  logic [7:0]       cmd_y1,
    input  logic [2:0]       cmd_colour,
    output logic [CNT_W-1:0] count,
    output logic             idle,
    output raster_command_t  rast_command,
    output logic [7:0]       rast_x0,
    output logic [7:0]       rast_y0,
    output logic [7:0]       rast_x1,
    output logic [7:0]       rast_y1,
    output logic [2:0]       rast_colour,
    output logic             rast_execute_request,
    input  logic             rast_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam raster_queue_entry_t c_PAYLOAD_RST = '{
        command: RASTER_CMD_NOP, x0: 8'd0, y0: 8'd0, x1: 8'd0, y1: 8'd0, colour: 3'd0
    };

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    raster_queue_entry_t w_wdata;
    raster_queue_entry_t w_head;
    raster_queue_entry_t r_payload;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign count     = w_count;
    assign w_wdata   = '{
        command: cmd_command, x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, colour: cmd_colour
    };

    sync_fifo #(
        .WIDTH (RASTER_ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_async),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The pop coincides with entry into S_REQ, so the head is consumed exactly once per issue.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !rast_busy) begin
                    w_state_next = S_REQ;
                    w_pop        = 1'b1;
                end
            end
            S_REQ: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!rast_busy) begin
                    if (!w_empty) begin
                        w_state_next = S_REQ;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rast_execute_request = (r_state == S_REQ);
        idle                 = w_empty && (r_state == S_IDLE) && !rast_busy;
    end

    // Payload stays put for the whole operation; the rasterizer reads some fields unlatched.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_payload <= c_PAYLOAD_RST;
        end else if (w_pop) begin
            r_payload <= w_head;
        end
    end

    assign rast_command = r_payload.command;
    assign rast_x0      = r_payload.x0;
    assign rast_y0      = r_payload.y0;
    assign rast_x1      = r_payload.x1;
    assign rast_y1      = r_payload.y1;
    assign rast_colour  = r_payload.colour;

endmodule
`default_nettype wire

// File: doc/raster_cmd_queue.md
Name: raster_cmd_queue

Overview:
- Command buffer between the CPU and the rasterizer. The CPU pushes draw commands (command, x0, y0, x1, y1, colour) through a valid/ready port without polling busy.
- The block stores commands in a FIFO and issues them to the rasterizer one at a time.
- Each issue is a single-cycle execute_request, never asserted while the rasterizer is busy.
- The payload is held stable for the whole operation, because the rasterizer consumes some fields (e.g. POINT x0/y0) unlatched.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2.
CNT_W, $clog2(DEPTH)+1, width of count output.

Ports:
clk  in  1  50MHz system clock
rst_async  in  1  asynchronous, active-high reset
cmd_valid  in  1  CPU presents a command
cmd_ready  out  1  queue can accept (count < DEPTH)
cmd_command  in  raster_command_t  command opcode
cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  8 each  coordinates
cmd_colour  in  3  pixel colour
count  out  CNT_W  entries currently buffered (not counting the in-flight command)
idle  out  1  queue empty, state IDLE and rast_busy low
rast_command  out  raster_command_t  to rasterizer command
rast_x0, rast_y0, rast_x1, rast_y1  out  8 each  to rasterizer
rast_colour  out  3  to rasterizer
rast_execute_request  out  1  one-cycle start pulse
rast_busy  in  1  rasterizer busy flag

Behaviour:
- Clock/reset: single clock clk. Reset rst_async is asynchronous and active-high.
- Reset values:
  - state IDLE; read/write pointers 0; count 0.
  - rast_execute_request 0; rast_command RASTER_CMD_NOP; all rast_* payload 0.
  - cmd_ready 1; idle 1 once rast_busy is low.
- Push:
  - An entry is written at a posedge with cmd_valid && cmd_ready.
  - cmd_ready is combinational from count; it is 0 when count == DEPTH.
  - No push-through when full, even if a pop occurs in the same cycle.
- Pop/issue:
  - The head is popped at the same edge that enters REQ.
  - The rast_* payload registers load the head at that edge and hold until the next entry into REQ.
- Simultaneous push and pop: count is unchanged. Pointers wrap modulo DEPTH.
- State machine (registered outputs; rast_execute_request = state==REQ):
  - IDLE: if count != 0 && !rast_busy -> REQ (pop).
  - REQ: exactly one cycle. rast_busy is still 0 here and rises at the closing edge. Always -> WAIT.
  - WAIT: if rast_busy -> stay. If !rast_busy && count != 0 -> REQ (pop). If !rast_busy && count == 0 -> IDLE.
- Latency and throughput:
  - Push at edge E0 into an empty queue with rasterizer idle: rast_execute_request is high during the cycle after E1, and the rasterizer latches at E2.
  - Back-to-back NOPs issue every 3 cycles.
- rast_execute_request is never high in a cycle where rast_busy is high. Violation is a bug; the bench asserts on it.
- count excludes the popped/in-flight entry.
- Reset mid-operation: all buffered entries are discarded and outputs return to reset values immediately. The rasterizer shares rst_async.
- Arithmetic: count is updated as count + push - pop, with no overflow possible by construction. The payload is passed unmodified; there is no coordinate clipping.

Decomposition:
- Package common:
  - raster_queue_entry_t: packed struct {raster_command_t command; logic [7:0] x0, y0, x1, y1; logic [2:0] colour;}.
  - RASTER_QUEUE_DEPTH = 8.
- Sub-module sync_fifo (parameterised WIDTH, DEPTH):
  - Ports: push, pop, wdata, rdata (head, show-ahead), count, full, empty.
- raster_cmd_queue holds the issue FSM and the payload registers.

Test Plan:
1. Reset with rast_busy=0 -> cmd_ready=1, count=0, idle=1, rast_execute_request=0, rast_command=RASTER_CMD_NOP, payload 0.
2. Push POINT x0=5, y0=7, colour=3 at edge E0; model rasterizer (busy for 1 cycle) -> rast_execute_request high exactly one cycle after E1; rast_x0=5, rast_y0=7, rast_colour=3 stable until next issue; idle=1 three cycles later.
3. Push FILL colour=6 then POINT x0=10, y0=20 in consecutive cycles; bench holds rast_busy=1 for 100 cycles after the FILL request -> count=1 throughout; POINT request only after rast_busy falls; FILL payload held unchanged for all 100 cycles.
4. rast_busy forced high after the first issue; push 10 commands back-to-back -> first issued, next 8 buffered (count=8), cmd_ready=0, 10th stalls; release busy -> 10th accepted the cycle after the next pop, FIFO order preserved, all 10 issued in order.
5. Push 4 NOPs with the model rasterizer -> requests spaced exactly 3 cycles apart; rast_execute_request && rast_busy never true.
6. rst_async asserted asynchronously in WAIT with count=3 -> outputs return to reset values before the next edge; after release, count=0, no request issued, idle=1.
